// File: rtl/lcd_cmd_feeder.sv
// Command feeder for the 8x8 LCD image controller: buffers host commands in a FIFO,
// issues them one at a time under the controller's busy flag, and shadows the cursor.
module lcd_cmd_feeder #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        host_cmd,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              busy,
  input  logic              done,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  output logic [ADDR_W:0]   fifo_count,
  output logic [2:0]        cur_x,
  output logic [2:0]        cur_y,
  output logic [7:0]        issued_cnt,
  output logic              overflow,
  output logic              seq_done
);

  localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYC);

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] POS_MIN   = 3'd0;
  localparam logic [2:0] POS_MAX   = 3'd6;
  localparam logic [2:0] POS_HOME  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Cursor moves clamp at the 0..6 window; non-motion commands leave it alone.
  function automatic logic [5:0] step_cursor(input logic [2:0] c,
                                             input logic [2:0] x,
                                             input logic [2:0] y);
    logic [2:0] nx;
    logic [2:0] ny;
    nx = x;
    ny = y;
    case (c)
      CMD_UP:    if (y > POS_MIN) ny = y - 3'd1; else ny = y;
      CMD_DOWN:  if (y < POS_MAX) ny = y + 3'd1; else ny = y;
      CMD_LEFT:  if (x > POS_MIN) nx = x - 3'd1; else nx = x;
      CMD_RIGHT: if (x < POS_MAX) nx = x + 3'd1; else nx = x;
      default: begin
        nx = x;
        ny = y;
      end
    endcase
    return {nx, ny};
  endfunction

  state_t              state_r, state_s;
  logic [2:0]          mem_r [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_s;
  logic [ADDR_W-1:0]   rd_ptr_r, rd_ptr_s;
  logic [ADDR_W:0]     count_r, count_s;
  logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_s;
  logic [2:0]          cmd_r, cmd_s;
  logic                cmd_valid_r, cmd_valid_s;
  logic [2:0]          cur_x_r, cur_y_r;
  logic [5:0]          cursor_s;
  logic [7:0]          issued_cnt_r, issued_cnt_s;
  logic                overflow_r, overflow_s;
  logic                seq_done_r, seq_done_s;

  logic                ready_s;
  logic                push_s;
  logic                pop_s;
  logic                flush_s;
  logic [2:0]          head_s;

  // Ready uses the pre-pop count, so a full FIFO refuses even on a popping edge.
  assign ready_s = (count_r < DEPTH_C) && ((state_r == ST_IDLE) || (state_r == ST_GAP));
  assign push_s  = host_valid && ready_s;
  assign head_s  = mem_r[rd_ptr_r];

  // Next-state logic: issue decision, gap countdown, drain and finish handling.
  always_comb begin
    state_s   = state_r;
    gap_cnt_s = gap_cnt_r;
    pop_s     = 1'b0;
    flush_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != CNT_ZERO) && !busy) begin
          pop_s = 1'b1;
          if (head_s == CMD_WRITE) begin
            state_s = ST_DRAIN;
          end else begin
            state_s   = ST_GAP;
            gap_cnt_s = GAP_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r != GAP_ZERO) begin
          gap_cnt_s = gap_cnt_r - GAP_ONE;
        end else begin
          gap_cnt_s = GAP_ZERO;
        end
        if (gap_cnt_r <= GAP_ONE) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_DRAIN: begin
        if (done) begin
          state_s = ST_FINISH;
          flush_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_FINISH: begin
        state_s = ST_FINISH;
        flush_s = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: FIFO bookkeeping, issue strobe, cursor and counters.
  always_comb begin
    count_s  = count_r;
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    if (flush_s) begin
      count_s  = CNT_ZERO;
      wr_ptr_s = PTR_ZERO;
      rd_ptr_s = PTR_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + CNT_ONE;
        2'b01:   count_s = count_r - CNT_ONE;
        default: count_s = count_r;
      endcase
      if (push_s) wr_ptr_s = wr_ptr_r + PTR_ONE; else wr_ptr_s = wr_ptr_r;
      if (pop_s)  rd_ptr_s = rd_ptr_r + PTR_ONE; else rd_ptr_s = rd_ptr_r;
    end

    cmd_valid_s = pop_s;
    if (pop_s) begin
      cmd_s    = head_s;
      cursor_s = step_cursor(head_s, cur_x_r, cur_y_r);
    end else begin
      cmd_s    = cmd_r;
      cursor_s = {cur_x_r, cur_y_r};
    end

    if (pop_s && (issued_cnt_r != 8'hFF)) begin
      issued_cnt_s = issued_cnt_r + 8'd1;
    end else begin
      issued_cnt_s = issued_cnt_r;
    end

    overflow_s = overflow_r | (host_valid & (count_r == DEPTH_C));
    seq_done_s = (state_s == ST_FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      gap_cnt_r    <= GAP_ZERO;
      cmd_r        <= 3'd0;
      cmd_valid_r  <= 1'b0;
      cur_x_r      <= POS_HOME;
      cur_y_r      <= POS_HOME;
      issued_cnt_r <= 8'd0;
      overflow_r   <= 1'b0;
      seq_done_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_ptr_r     <= wr_ptr_s;
      rd_ptr_r     <= rd_ptr_s;
      count_r      <= count_s;
      gap_cnt_r    <= gap_cnt_s;
      cmd_r        <= cmd_s;
      cmd_valid_r  <= cmd_valid_s;
      cur_x_r      <= cursor_s[5:3];
      cur_y_r      <= cursor_s[2:0];
      issued_cnt_r <= issued_cnt_s;
      overflow_r   <= overflow_s;
      seq_done_r   <= seq_done_s;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 3'd0;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= host_cmd;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign host_ready = ready_s;
  assign cmd        = cmd_r;
  assign cmd_valid  = cmd_valid_r;
  assign fifo_count = count_r;
  assign cur_x      = cur_x_r;
  assign cur_y      = cur_y_r;
  assign issued_cnt = issued_cnt_r;
  assign overflow   = overflow_r;
  assign seq_done   = seq_done_r;

endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// Self-checking bench for lcd_cmd_feeder: table of cursor moves plus hand-written
// sequences, with expected issues queued at drive time and compared on each cmd_valid.
module tb_lcd_cmd_feeder;

  logic       clk = 1'b0;
  logic       reset, host_valid, busy, done;
  logic [2:0] host_cmd;
  logic       host_ready, cmd_valid, overflow, seq_done;
  logic [2:0] cmd, cur_x, cur_y;
  logic [3:0] fifo_count;
  logic [7:0] issued_cnt;

  lcd_cmd_feeder dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
    .host_ready(host_ready), .busy(busy), .done(done), .cmd(cmd),
    .cmd_valid(cmd_valid), .fifo_count(fifo_count), .cur_x(cur_x), .cur_y(cur_y),
    .issued_cnt(issued_cnt), .overflow(overflow), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cmd;
    logic [2:0] x;
    logic [2:0] y;
    logic [7:0] cnt;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];
  int   issue_cyc_q[$];
  exp_t mon_e;
  exp_t tbl[25];
  exp_t t3[8];
  int   push_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every issue strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (mon_en && (cmd_valid !== 1'b0)) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_issue: cmd_valid=%b cmd=%0d, expected no issue", cmd_valid, cmd);
      end else begin
        mon_e = sb_q.pop_front();
        chk("issue_cmd", cmd, mon_e.cmd);
        chk("issue_cur_x", cur_x, mon_e.x);
        chk("issue_cur_y", cur_y, mon_e.y);
        chk("issue_cnt", issued_cnt, mon_e.cnt);
        issue_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [2:0] c, input logic [2:0] x,
                              input logic [2:0] y, input logic [7:0] n);
    sb_q.push_back('{c, x, y, n});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb_q.delete();
    issue_cyc_q.delete();
  endtask

  task automatic check_reset();
    chk("rst_cmd", cmd, 3'd0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_cur_x", cur_x, 3'd3);
    chk("rst_cur_y", cur_y, 3'd3);
    chk("rst_issued", issued_cnt, 8'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_seq_done", seq_done, 1'b0);
    chk("rst_fifo_count", fifo_count, 4'd0);
    chk("rst_host_ready", host_ready, 1'b1);
  endtask

  // Offer one command, dropping host_valid while the FIFO refuses so no overflow is provoked.
  task automatic push_wait(input logic [2:0] c);
    int k = 0;
    while (host_ready !== 1'b1 && k < 200) begin
      host_valid = 1'b0;
      tick();
      k++;
    end
    if (k >= 200) chk("push_ready_timeout", host_ready, 1'b1);
    host_valid = 1'b1;
    host_cmd   = c;
    tick();
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_cmd = 3'd0; busy = 1'b1; done = 1'b0;

    // {cmd, expected cur_x, cur_y, issued_cnt} walking from (3,3) into every clamp
    tbl[0]  = '{3'd4, 3'd4, 3'd3, 8'd1};   tbl[1]  = '{3'd4, 3'd5, 3'd3, 8'd2};
    tbl[2]  = '{3'd4, 3'd6, 3'd3, 8'd3};   tbl[3]  = '{3'd4, 3'd6, 3'd3, 8'd4};
    tbl[4]  = '{3'd1, 3'd6, 3'd2, 8'd5};   tbl[5]  = '{3'd1, 3'd6, 3'd1, 8'd6};
    tbl[6]  = '{3'd1, 3'd6, 3'd0, 8'd7};   tbl[7]  = '{3'd1, 3'd6, 3'd0, 8'd8};
    tbl[8]  = '{3'd3, 3'd5, 3'd0, 8'd9};   tbl[9]  = '{3'd5, 3'd5, 3'd0, 8'd10};
    tbl[10] = '{3'd2, 3'd5, 3'd1, 8'd11};  tbl[11] = '{3'd6, 3'd5, 3'd1, 8'd12};
    tbl[12] = '{3'd3, 3'd4, 3'd1, 8'd13};  tbl[13] = '{3'd7, 3'd4, 3'd1, 8'd14};
    tbl[14] = '{3'd3, 3'd3, 3'd1, 8'd15};  tbl[15] = '{3'd3, 3'd2, 3'd1, 8'd16};
    tbl[16] = '{3'd3, 3'd1, 3'd1, 8'd17};  tbl[17] = '{3'd3, 3'd0, 3'd1, 8'd18};
    tbl[18] = '{3'd3, 3'd0, 3'd1, 8'd19};  tbl[19] = '{3'd2, 3'd0, 3'd2, 8'd20};
    tbl[20] = '{3'd2, 3'd0, 3'd3, 8'd21};  tbl[21] = '{3'd2, 3'd0, 3'd4, 8'd22};
    tbl[22] = '{3'd2, 3'd0, 3'd5, 8'd23};  tbl[23] = '{3'd2, 3'd0, 3'd6, 8'd24};
    tbl[24] = '{3'd2, 3'd0, 3'd6, 8'd25};

    t3[0] = '{3'd5, 3'd3, 3'd3, 8'd1};  t3[1] = '{3'd6, 3'd3, 3'd3, 8'd2};
    t3[2] = '{3'd7, 3'd3, 3'd3, 8'd3};  t3[3] = '{3'd1, 3'd3, 3'd2, 8'd4};
    t3[4] = '{3'd2, 3'd3, 3'd3, 8'd5};  t3[5] = '{3'd3, 3'd2, 3'd3, 8'd6};
    t3[6] = '{3'd4, 3'd3, 3'd3, 8'd7};  t3[7] = '{3'd5, 3'd3, 3'd3, 8'd8};

    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    check_reset();

    // Issue held off while busy, then a single DOWN once busy falls
    push_wait(3'd2);
    host_valid = 1'b0;
    repeat (4) tick();
    chk("busy_hold_count", fifo_count, 4'd1);
    expect_issue(3'd2, 3'd3, 3'd4, 8'd1);
    busy = 1'b0;
    wait_drain(10);
    tick();
    chk("t1_fifo_count", fifo_count, 4'd0);
    chk("t1_cmd_hold", cmd, 3'd2);
    chk("t1_cmd_valid_low", cmd_valid, 1'b0);

    // Table walk with done held high outside DRAIN
    do_reset();
    busy = 1'b0;
    done = 1'b1;
    for (int i = 0; i < 25; i++) begin
      expect_issue(tbl[i].cmd, tbl[i].x, tbl[i].y, tbl[i].cnt);
      push_wait(tbl[i].cmd);
    end
    host_valid = 1'b0;
    wait_drain(80);
    done = 1'b0;
    for (int i = 0; i < 3; i++) chk("issue_spacing", issue_cyc_q[i+1] - issue_cyc_q[i], 2);
    chk("t2_overflow", overflow, 1'b0);
    chk("t2_seq_done", seq_done, 1'b0);

    // Nine pushes into a stalled FIFO: eight kept, ninth dropped with overflow
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      host_valid = 1'b1;
      host_cmd   = (i < 8) ? t3[i].cmd : 3'd1;
      if (i < 8) expect_issue(t3[i].cmd, t3[i].x, t3[i].y, t3[i].cnt);
      tick();
      if (i == 7) chk("t3_no_ovf_at_8", overflow, 1'b0);
    end
    host_valid = 1'b0;
    chk("t3_full_count", fifo_count, 4'd8);
    chk("t3_full_ready", host_ready, 1'b0);
    chk("t3_overflow", overflow, 1'b1);
    busy = 1'b0;
    wait_drain(40);
    chk("t3_overflow_sticky", overflow, 1'b1);
    chk("t3_drained", fifo_count, 4'd0);

    // Full FIFO on an issue edge: push refused, pop proceeds
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_valid = 1'b1;
      host_cmd   = 3'd4;
      expect_issue(3'd4, (i < 3) ? 3'(4 + i) : 3'd6, 3'd3, 8'(i + 1));
      tick();
    end
    chk("t6_count8", fifo_count, 4'd8);
    chk("t6_no_ovf", overflow, 1'b0);
    busy     = 1'b0;
    host_cmd = 3'd1;
    tick();
    host_valid = 1'b0;
    chk("t6_count7", fifo_count, 4'd7);
    chk("t6_overflow", overflow, 1'b1);
    wait_drain(40);
    chk("t6_drained", fifo_count, 4'd0);

    // UP, WRITE, LEFT: WRITE parks in DRAIN until done, then flush
    do_reset();
    busy = 1'b0;
    expect_issue(3'd1, 3'd3, 3'd2, 8'd1);
    expect_issue(3'd0, 3'd3, 3'd2, 8'd2);
    push_wait(3'd1);
    push_wait(3'd0);
    push_wait(3'd3);
    host_valid = 1'b0;
    wait_drain(10);
    repeat (3) tick();
    chk("t4_drain_ready", host_ready, 1'b0);
    chk("t4_drain_count", fifo_count, 4'd1);
    chk("t4_drain_seq_done", seq_done, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t4_seq_done", seq_done, 1'b1);
    chk("t4_flushed", fifo_count, 4'd0);
    chk("t4_finish_ready", host_ready, 1'b0);
    host_valid = 1'b1;
    host_cmd   = 3'd4;
    repeat (3) tick();
    host_valid = 1'b0;
    chk("t4_finish_count", fifo_count, 4'd0);
    chk("t4_finish_hold", seq_done, 1'b1);
    chk("t4_finish_ovf", overflow, 1'b0);

    // Reset in DRAIN with two queued entries, then normal issue and minimum latency
    do_reset();
    busy       = 1'b1;
    host_valid = 1'b1;
    host_cmd   = 3'd0; tick();
    host_cmd   = 3'd5; tick();
    host_cmd   = 3'd5; tick();
    host_valid = 1'b0;
    expect_issue(3'd0, 3'd3, 3'd3, 8'd1);
    busy = 1'b0;
    wait_drain(10);
    tick();
    chk("t5_queued", fifo_count, 4'd2);
    chk("t5_drain_ready", host_ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    issue_cyc_q.delete();
    check_reset();
    expect_issue(3'd3, 3'd2, 3'd3, 8'd1);
    push_wait(3'd3);
    push_cyc   = cyc;
    host_valid = 1'b0;
    wait_drain(10);
    chk("t5_latency", issue_cyc_q[0] - push_cyc, 1);

    // issued_cnt saturates at 255
    do_reset();
    busy = 1'b0;
    for (int i = 0; i < 258; i++) begin
      expect_issue(3'd5, 3'd3, 3'd3, (i < 255) ? 8'(i + 1) : 8'd255);
      push_wait(3'd5);
    end
    host_valid = 1'b0;
    wait_drain(100);
    chk("sat_issued", issued_cnt, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_feeder.md
Name: lcd_cmd_feeder

Overview:
Upstream command source for the 8x8 LCD image controller. A host pushes 3-bit commands into an internal FIFO. The block issues them one at a time on the controller's cmd/cmd_valid port, gated by the controller's busy flag. It keeps a shadow copy of the 2x2 cursor position, and after issuing WRITE it waits for the controller's done flag before it reports completion.

Parameters:
DEPTH, 8, FIFO entries (power of 2)
ADDR_W, 3, log2(DEPTH)
GAP_CYC, 1, idle cycles forced after each issue (covers the controller's busy lag)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
host_cmd  input  3  command to enqueue (0 WRITE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 AVG, 6 MIRX, 7 MIRY)
host_valid  input  1  host offers host_cmd this cycle
host_ready  output  1  FIFO accepts this cycle
busy  input  1  controller busy (from image controller)
done  input  1  controller finished writing the frame
cmd  output  3  command to controller
cmd_valid  output  1  one-cycle issue strobe
fifo_count  output  ADDR_W+1  occupied entries
cur_x  output  3  shadow cursor x
cur_y  output  3  shadow cursor y
issued_cnt  output  8  commands issued, saturating
overflow  output  1  sticky: push attempted while full
seq_done  output  1  frame written; sequence complete

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset applies at any cycle, including mid-DRAIN, and returns the block to the values below.
- Reset values: state=IDLE, FIFO empty, fifo_count=0, cmd=0, cmd_valid=0, cur_x=3, cur_y=3, issued_cnt=0, overflow=0, seq_done=0.
- FIFO:
  - Circular buffer with separate read and write pointers. Pointers wrap modulo DEPTH.
  - host_ready is combinational: (fifo_count<DEPTH) && (state is IDLE or GAP).
  - A push occurs when host_valid && host_ready. The entry is visible from the next cycle.
  - host_valid while fifo_count==DEPTH sets overflow (sticky until reset); the data is dropped.
  - Simultaneous push and pop: fifo_count is unchanged. host_ready uses the pre-pop count, so a full FIFO rejects the push even when a pop happens in the same cycle.
- State machine (IDLE, GAP, DRAIN, FINISH):
  - IDLE: at an edge where fifo_count>0 and busy==0, pop the head and register cmd=head and cmd_valid=1.
    - Head != WRITE: go to GAP, load the gap counter with GAP_CYC.
    - Head == WRITE: go to DRAIN.
    - If busy==1 or the FIFO is empty: stay in IDLE with cmd_valid=0.
  - cmd_valid is high for exactly one cycle per issue. cmd holds the last issued value between issues.
  - GAP: cmd_valid=0. Decrement the counter each cycle and ignore busy. Return to IDLE when the counter reaches 0 (GAP_CYC=1 gives exactly one idle cycle).
  - DRAIN: no issues, pushes refused. On the first cycle with done==1, go to FINISH.
  - FINISH: seq_done=1. The FIFO is flushed: pointers cleared, fifo_count=0. host_ready=0. Remain here until reset.
  - done==1 seen in IDLE or GAP is ignored.
- Minimum latency: a push accepted at edge k can be issued at edge k+1, so cmd_valid is high in the cycle after edge k+1. Back-to-back issues are therefore spaced GAP_CYC+1 cycles apart.
- Shadow cursor: updated at the issue edge, visible together with cmd_valid.
  - UP: cur_y-- if cur_y>0.
  - DOWN: cur_y++ if cur_y<6.
  - LEFT: cur_x-- if cur_x>0.
  - RIGHT: cur_x++ if cur_x<6.
  - At the limits the position holds, but the command is still issued and counted.
  - Other commands leave the cursor unchanged.
- issued_cnt increments on every issue, WRITE included. It saturates at 255.

Test Plan:
1. Reset with busy=1, push 2 (DOWN) -> no cmd_valid while busy=1. After busy falls: one cmd_valid pulse with cmd=2, cur_y=4, issued_cnt=1, fifo_count=0.
2. busy=0, push 4,4,4,4 back-to-back -> four cmd_valid pulses 2 cycles apart (GAP_CYC=1). cur_x saturates at 6 after the third pulse, issued_cnt=4.
3. busy=1, push 9 commands with host_valid held -> the first 8 are accepted, fifo_count=8, host_ready=0, ninth dropped, overflow=1 and stays 1 after the FIFO drains.
4. Push 1,0,3 with busy=0 -> cmd 1 then cmd 0 are issued, state DRAIN, 3 is not issued, host_ready=0. Assert done=1 -> seq_done=1 next cycle, fifo_count=0, no further cmd_valid.
5. Assert reset while in DRAIN with 2 entries queued -> next cycle all outputs at reset values, cur_x=cur_y=3, normal issue resumes once busy=0.
6. FIFO holds 8, busy=0, host_valid=1 during the issue edge -> push rejected (overflow=1), pop proceeds, fifo_count=7.
